// File: rtl/seq_mult_32.sv
`default_nettype none
// ============================================================================
// Module   : seq_mult_32 (with helper seq_mult_32_cla32)
// Purpose  : Multi-cycle 32x32 -> 64-bit radix-2 shift-add multiplier for the
//            execute stage. One partial-product add per cycle through a
//            32-bit carry-lookahead adder. Signed and unsigned operands.
// Ports    : clk        rising-edge clock
//            rst        asynchronous active-high reset
//            start      request, accepted only in IDLE
//            is_signed  1 = two's complement operands, sampled with start
//            a, b       multiplicand / multiplier, sampled with start
//            busy       high while CALC/SIGN are in progress
//            done       one-cycle pulse when product is valid
//            product    64-bit result, held until the next result is written
// Config   : MULT_ZERO_SKIP_EN - when defined, a zero operand bypasses the
//            32 CALC iterations and completes after one intermediate cycle.
// Revision : 1.0 - initial release
// ============================================================================

// 32-bit adder built from 4-bit lookahead groups, group carries chained.
module seq_mult_32_cla32 (
  input  logic [31:0] x,
  input  logic [31:0] y,
  input  logic        cin,
  output logic [31:0] sum,
  output logic        cout
);
  logic [31:0] g, p, cv;
  logic [3:0]  gg, pp;
  logic        carry;

  assign g = x & y;
  assign p = x ^ y;

  always_comb begin
    cv    = '0;
    gg    = '0;
    pp    = '0;
    carry = cin;
    for (int k = 0; k < 8; k++) begin
      gg = g[4*k +: 4];
      pp = p[4*k +: 4];
      cv[4*k]   = carry;
      cv[4*k+1] = gg[0] | (pp[0] & carry);
      cv[4*k+2] = gg[1] | (pp[1] & gg[0]) | (pp[1] & pp[0] & carry);
      cv[4*k+3] = gg[2] | (pp[2] & gg[1]) | (pp[2] & pp[1] & gg[0])
                | (pp[2] & pp[1] & pp[0] & carry);
      carry     = gg[3] | (pp[3] & gg[2]) | (pp[3] & pp[2] & gg[1])
                | (pp[3] & pp[2] & pp[1] & gg[0])
                | (pp[3] & pp[2] & pp[1] & pp[0] & carry);
    end
  end

  assign sum  = p ^ cv;
  assign cout = carry;
endmodule

module seq_mult_32 #(
  parameter int WIDTH = 32  // adder is fixed at 32 bits; only 32 is legal
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               is_signed,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_SIGN = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [4:0]         count_q, count_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]   mplr_q, mplr_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic               neg_q, neg_d;
  logic [2*WIDTH-1:0] product_q, product_d;

  // Two adder instances: in IDLE they negate a and b in parallel, in CALC the
  // high one accumulates, in SIGN they form one 64-bit negation (lo -> hi carry).
  logic [WIDTH-1:0] lo_x, lo_y, lo_sum, hi_x, hi_y, hi_sum;
  logic             lo_cin, lo_cout, hi_cin, hi_cout;

  seq_mult_32_cla32 u_add_lo (.x(lo_x), .y(lo_y), .cin(lo_cin), .sum(lo_sum), .cout(lo_cout));
  seq_mult_32_cla32 u_add_hi (.x(hi_x), .y(hi_y), .cin(hi_cin), .sum(hi_sum), .cout(hi_cout));

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    acc_d     = acc_q;
    mplr_d    = mplr_q;
    mcand_d   = mcand_q;
    neg_d     = neg_q;
    product_d = product_q;
    lo_x      = '0;
    lo_y      = '0;
    lo_cin    = 1'b0;
    hi_x      = '0;
    hi_y      = '0;
    hi_cin    = 1'b0;

    case (state_q)
      S_IDLE: begin
        lo_x   = ~a;
        lo_cin = 1'b1;
        hi_x   = ~b;
        hi_cin = 1'b1;
        if (start) begin
          // 0x8000_0000 negates to itself, which is the correct unsigned magnitude.
          mcand_d = (is_signed && a[WIDTH-1]) ? lo_sum : a;
          mplr_d  = (is_signed && b[WIDTH-1]) ? hi_sum : b;
          neg_d   = is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
          acc_d   = '0;
          count_d = '0;
          state_d = S_CALC;
`ifdef MULT_ZERO_SKIP_EN
          // Zeroed registers make the single SIGN pass a no-op yielding 0.
          if ((a == '0) || (b == '0)) begin
            mcand_d = '0;
            mplr_d  = '0;
            neg_d   = 1'b0;
            state_d = S_SIGN;
          end
`endif
        end
      end
      S_CALC: begin
        hi_x    = acc_q;
        hi_y    = mplr_q[0] ? mcand_q : '0;
        // {carry, sum, mplr} shifted right by one.
        acc_d   = {hi_cout, hi_sum[WIDTH-1:1]};
        mplr_d  = {hi_sum[0], mplr_q[WIDTH-1:1]};
        count_d = count_q + 5'd1;
        if (count_q == 5'd31) begin
          state_d = S_SIGN;
        end
      end
      S_SIGN: begin
        lo_x   = ~mplr_q;
        lo_cin = 1'b1;
        hi_x   = ~acc_q;
        hi_cin = lo_cout;
        // Product is written on entry to DONE so it is valid while done is high.
        product_d = neg_q ? {hi_sum, lo_sum} : {acc_q, mplr_q};
        state_d   = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      count_q   <= '0;
      acc_q     <= '0;
      mplr_q    <= '0;
      mcand_q   <= '0;
      neg_q     <= 1'b0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      acc_q     <= acc_d;
      mplr_q    <= mplr_d;
      mcand_q   <= mcand_d;
      neg_q     <= neg_d;
      product_q <= product_d;
    end
  end

  assign busy    = (state_q == S_CALC) || (state_q == S_SIGN);
  assign done    = (state_q == S_DONE);
  assign product = product_q;
endmodule
`default_nettype wire

// File: tb/tb_seq_mult_32.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_mult_32
// Purpose  : Scoreboard bench for seq_mult_32. A driver issues operand pairs
//            and queues the expected product and completion cycle; a monitor
//            pops and compares on every done pulse and checks product holds.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seq_mult_32;
  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        is_signed;
  logic [31:0] a, b;
  logic        busy, done;
  logic [63:0] product;

  seq_mult_32 #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .is_signed(is_signed),
    .a(a), .b(b), .busy(busy), .done(done), .product(product)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [63:0] prod;
    int          due;
    string       name;
  } exp_t;

  exp_t        q[$];
  int          checks = 0;
  int          passed = 0;
  logic [63:0] last_prod = '0;
  bit          dead = 1'b0;
  int          done_seen = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] want);
    checks++;
    if (act === want) passed++;
    else $display("FAIL %s: got %h required %h", nm, act, want);
  endtask

  function automatic logic [63:0] ref_mul(input logic [31:0] x, input logic [31:0] y, input logic s);
    longint sx, sy;
    if (s) begin
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      return 64'(sx * sy);
    end
    return {32'b0, x} * {32'b0, y};
  endfunction

  // Monitor: compares on done, checks product is held otherwise.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (done) begin
        done_seen++;
        if (q.size() == 0) begin
          check("unexpected_done", {63'b0, done}, 64'd0);
        end else begin
          e = q.pop_front();
          check({e.name, " product"}, product, e.prod);
          check({e.name, " done_cycle"}, 64'(cyc), 64'(e.due));
          last_prod = e.prod;
        end
      end else begin
        if (product !== last_prod) check("product_hold", product, last_prod);
        if (q.size() != 0 && cyc > q[0].due) begin
          e = q.pop_front();
          check({e.name, " overdue"}, 64'(cyc), 64'(e.due));
        end
      end
    end
  end

  // Drives a request and holds start until the DUT is idle; the request is
  // accepted at the following rising edge.
  task automatic issue(input logic [31:0] x, input logic [31:0] y, input logic s,
                       input logic [63:0] want, input string nm, input bit keep);
    int   guard;
    exp_t e;
    if (dead) return;
    @(negedge clk);
    a = x; b = y; is_signed = s; start = 1'b1;
    guard = 0;
    while (busy || done) begin
      @(negedge clk);
      guard++;
      if (guard > 100) begin
        check({nm, " idle_timeout"}, 64'(guard), 64'd0);
        dead  = 1'b1;
        start = 1'b0;
        return;
      end
    end
    e.prod = want;
    e.name = nm;
`ifdef MULT_ZERO_SKIP_EN
    e.due = cyc + (((x == 0) || (y == 0)) ? 2 : 34);
`else
    e.due = cyc + 34;
`endif
    q.push_back(e);
    @(posedge clk);
    #1;
    if (!keep) begin
      start = 1'b0;
      a = $urandom;
      b = $urandom;
      is_signed = 1'($urandom_range(0, 1));
    end
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0:       return 32'h0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h1;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int          g;
    logic [31:0] x, y;
    logic        s;
    rst = 1'b1; start = 1'b0; is_signed = 1'b0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    check("reset busy", {63'b0, busy}, 64'd0);
    check("reset done", {63'b0, done}, 64'd0);
    check("reset product", product, 64'd0);

    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001, "unsigned_max", 1'b0);
    issue(32'hFFFF_FFF9, 32'd6, 1'b1, 64'hFFFF_FFFF_FFFF_FFD6, "signed_m7x6", 1'b0);
    issue(32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000, "signed_min_sq", 1'b0);
    issue(32'd3, 32'd4, 1'b0, 64'd12, "busy_3x4", 1'b1);
    issue(32'd5, 32'd5, 1'b0, 64'd25, "busy_5x5", 1'b0);
    issue(32'd0, 32'h1234, 1'b0, 64'd0, "zero_a", 1'b0);
    issue(32'h1234, 32'd0, 1'b1, 64'd0, "zero_b", 1'b0);

    for (int i = 0; i < 1000; i++) begin
      x = pick();
      y = pick();
      s = 1'($urandom_range(0, 1));
      issue(x, y, s, ref_mul(x, y, s), "random", 1'b0);
    end

    // Drain, then abort an operation mid-CALC with reset.
    g = 0;
    while (q.size() != 0 && g < 100) begin @(negedge clk); g++; end
    check("drain", 64'(q.size()), 64'd0);

    issue(32'h0001_2345, 32'h0006_789A, 1'b0, 64'd0, "aborted", 1'b0);
    repeat (10) @(negedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    q.delete();
    last_prod = '0;
    #2 rst = 1'b0;
    @(negedge clk);
    check("abort busy", {63'b0, busy}, 64'd0);
    check("abort done", {63'b0, done}, 64'd0);
    check("abort product", product, 64'd0);
    done_seen = 0;
    repeat (40) @(negedge clk);
    check("abort no_done", 64'(done_seen), 64'd0);

    issue(32'd7, 32'd9, 1'b0, 64'd63, "after_abort", 1'b0);
    g = 0;
    while (q.size() != 0 && g < 100) begin @(negedge clk); g++; end
    check("final_drain", 64'(q.size()), 64'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
`default_nettype wire
